// File: rtl/eeprom_write_seq.sv
// -----------------------------------------------------------------------------
// eeprom_write_seq
//   Command sequencer that sits upstream of the SPI byte shifter for the
//   EEPROM. It takes one byte-write request (16-bit address + data) and runs
//   the complete EEPROM transaction:
//     WREN frame (0x06), nCS gap, WRITE frame (0x02, ADDR_H, ADDR_L, DATA),
//     then a timed write-cycle wait.
//   The block drives the shifter's load strobe and byte input, and it owns
//   the EEPROM chip select.
//
// Ports
//   clk_i        system clock
//   reset_ni     asynchronous reset, active low
//   wr_req_i     write request, sampled only in IDLE
//   wr_addr_i    EEPROM byte address, captured on acceptance
//   wr_data_i    data byte, captured on acceptance
//   busy_o       high from the cycle after acceptance until the done cycle
//   done_o       1-cycle pulse when the write-cycle wait expires
//   ld_data_o    1-cycle load strobe to the shifter
//   datain_o     byte to the shifter, valid while ld_data_o=1
//   spi_done_i   shifter idle flag (1 = idle)
//   nCS_o        EEPROM chip select, active low
//
// Parameters (all in clk cycles; each must be at least 1)
//   CS_SETUP  nCS falling to the first load of a frame
//   CS_HOLD   last byte done to nCS rising
//   CS_GAP    nCS high time between the WREN and WRITE frames
//   TWC       write-cycle wait after the WRITE frame
// -----------------------------------------------------------------------------
module eeprom_write_seq #(
   parameter int unsigned CS_SETUP = 4,
   parameter int unsigned CS_HOLD  = 4,
   parameter int unsigned CS_GAP   = 8,
   parameter int unsigned TWC      = 250000
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        wr_req_i,
   input  logic [15:0] wr_addr_i,
   input  logic [7:0]  wr_data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        ld_data_o,
   output logic [7:0]  datain_o,
   input  logic        spi_done_i,
   output logic        nCS_o
);

   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // One shared counter serves every timed state, so it is sized for the
   // largest count (normally TWC).
   localparam int unsigned CMAX = umax(umax(TWC, CS_GAP), umax(CS_SETUP, CS_HOLD));
   localparam int unsigned CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
   localparam logic [CW-1:0] TWC_LAST   = CW'(TWC - 1);
   localparam logic [CW-1:0] ARM_LAST   = CW'(1);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_SETUP, S_LOAD, S_ARM, S_SHIFT, S_HOLD, S_GAP, S_TWC
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      idx_q;
   logic            wr_frame_q;  // 0 = WREN frame, 1 = WRITE frame
   logic [15:0]     addr_q;
   logic [7:0]      data_q;
   logic            ncs_q, ld_q, busy_q, done_q;
   logic [7:0]      datain_q;

   logic [1:0]      idx_d;
   logic [7:0]      byte_cur_d, byte_nxt_d;
   logic            last_byte_d;

   function automatic logic [7:0] frame_byte(input logic        wr_frame,
                                             input logic [1:0]  idx,
                                             input logic [15:0] a,
                                             input logic [7:0]  d);
      if (!wr_frame) return 8'h06;
      case (idx)
         2'd0:    return 8'h02;
         2'd1:    return a[15:8];
         2'd2:    return a[7:0];
         default: return d;
      endcase
   endfunction

   always_comb begin
      idx_d       = idx_q + 2'd1;
      byte_cur_d  = frame_byte(wr_frame_q, idx_q, addr_q, data_q);
      byte_nxt_d  = frame_byte(wr_frame_q, idx_d, addr_q, data_q);
      last_byte_d = wr_frame_q ? (idx_q == 2'd3) : 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_INIT;
         cnt_q      <= '0;
         idx_q      <= '0;
         wr_frame_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         ncs_q      <= 1'b1;
         ld_q       <= 1'b0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         datain_q   <= '0;
      end else begin
         ld_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            // Shifter clocks out a dummy byte after its own reset; wait it out.
            S_INIT: if (spi_done_i) begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            // A request in the done cycle is ignored; it is taken next cycle.
            S_IDLE: if (wr_req_i && !done_q) begin
               addr_q     <= wr_addr_i;
               data_q     <= wr_data_i;
               busy_q     <= 1'b1;
               ncs_q      <= 1'b0;
               cnt_q      <= '0;
               idx_q      <= '0;
               wr_frame_q <= 1'b0;
               state_q    <= S_SETUP;
            end
            S_SETUP: if (cnt_q == SETUP_LAST) begin
               cnt_q    <= '0;
               ld_q     <= 1'b1;
               datain_q <= byte_cur_d;
               state_q  <= S_LOAD;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            S_LOAD: begin
               cnt_q   <= '0;
               state_q <= S_ARM;
            end
            // Shifter should drop spi_done the cycle after the load; if it is
            // still idle after two cycles the load was missed, so reload.
            S_ARM: if (!spi_done_i) begin
               state_q <= S_SHIFT;
            end else if (cnt_q == ARM_LAST) begin
               cnt_q    <= '0;
               ld_q     <= 1'b1;
               datain_q <= byte_cur_d;
               state_q  <= S_LOAD;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            S_SHIFT: if (spi_done_i) begin
               if (!last_byte_d) begin
                  idx_q    <= idx_d;
                  ld_q     <= 1'b1;
                  datain_q <= byte_nxt_d;
                  state_q  <= S_LOAD;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: if (cnt_q == HOLD_LAST) begin
               cnt_q   <= '0;
               ncs_q   <= 1'b1;
               state_q <= wr_frame_q ? S_TWC : S_GAP;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            S_GAP: if (cnt_q == GAP_LAST) begin
               cnt_q      <= '0;
               ncs_q      <= 1'b0;
               wr_frame_q <= 1'b1;
               idx_q      <= '0;
               state_q    <= S_SETUP;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            S_TWC: if (cnt_q == TWC_LAST) begin
               cnt_q   <= '0;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign ld_data_o = ld_q;
   assign datain_o  = datain_q;
   assign nCS_o     = ncs_q;

endmodule

// File: tb/tb_eeprom_write_seq.sv
// -----------------------------------------------------------------------------
// tb_eeprom_write_seq
//   Directed bench for eeprom_write_seq. A behavioural SPI shifter drives
//   spi_done and a serial stream (8 clk per bit, 64 clk per byte); the stream
//   is decoded while nCS is low. Monitors log loaded bytes, done pulses, nCS
//   edges and protocol violations.
// -----------------------------------------------------------------------------
module tb_eeprom_write_seq;
   localparam int TWC_T = 100;

   logic        clk = 1'b0, rst_n = 1'b0, wr_req = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        busy, done, ld_data, nCS, spi_done;
   logic [7:0]  datain;

   always #5 clk = ~clk;

   eeprom_write_seq #(.CS_SETUP(4), .CS_HOLD(4), .CS_GAP(8), .TWC(TWC_T)) dut (
      .clk_i(clk), .reset_ni(rst_n), .wr_req_i(wr_req), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .busy_o(busy), .done_o(done), .ld_data_o(ld_data),
      .datain_o(datain), .spi_done_i(spi_done), .nCS_o(nCS));

   // Shifter model: dummy byte after reset, then one byte per load.
   logic       sh_busy, sclk, sdout;
   logic [5:0] tick;
   logic [7:0] shreg;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_busy <= 1'b1; tick <= '0; spi_done <= 1'b0; shreg <= '0;
      end else if (ld_data) begin
         shreg <= datain; sh_busy <= 1'b1; tick <= '0; spi_done <= 1'b0;
      end else if (sh_busy) begin
         tick <= tick + 6'd1;
         if (tick == 6'd63) begin
            sh_busy <= 1'b0; spi_done <= 1'b1;
         end
      end
   end
   assign sclk  = sh_busy & tick[2];
   assign sdout = shreg[3'd7 - tick[5:3]];

   bit rxq[$];
   always @(posedge sclk) if (!nCS) rxq.push_back(sdout);

   // Monitors (sample pre-edge values)
   int         cyc = 0, done_cnt = 0, rise_cnt = 0, viol_ld = 0, viol_cs = 0;
   int         rise_cyc = 0, done_cyc = 0;
   logic       ncs_prev = 1'b1, sd_prev = 1'b1;
   logic [7:0] ldq[$];
   int         gapq[$];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         ncs_prev <= 1'b1; sd_prev <= 1'b1;
      end else begin
         if (ld_data) begin
            ldq.push_back(datain);
            if (nCS) viol_ld <= viol_ld + 1;
         end
         if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
         if (nCS && !ncs_prev) begin rise_cnt <= rise_cnt + 1; rise_cyc <= cyc; end
         if (!nCS && ncs_prev) gapq.push_back(cyc - rise_cyc);
         if ((nCS !== ncs_prev) && !sd_prev) viol_cs <= viol_cs + 1;
         ncs_prev <= nCS;
         sd_prev  <= spi_done;
      end
   end

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [39:0] ld5(input int s);
      logic [39:0] r = '0;
      for (int k = 0; k < 5; k++) r = {r[31:0], (s + k < ldq.size()) ? ldq[s+k] : 8'h00};
      return r;
   endfunction

   function automatic logic [39:0] rx40(input int s);
      logic [39:0] r = '0;
      for (int k = 0; k < 40; k++) r = {r[38:0], (s + k < rxq.size()) ? rxq[s+k] : 1'b0};
      return r;
   endfunction

   task automatic start_wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_addr = a; wr_data = d; wr_req = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, l0, g0, r0, b0, d0;
      // ---- T1 reset ----
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ncs",    64'(nCS), 64'(1));
      chk("rst_busy",   64'(busy), 64'(1));
      chk("rst_ld",     64'(ld_data), 64'(0));
      chk("rst_done",   64'(done), 64'(0));
      chk("rst_datain", 64'(datain), 64'(0));
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100 && spi_done !== 1'b1; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || nCS !== 1'b1) bad++;
      end
      chk("t1_busy_in_init", 64'(bad), 64'(0));
      chk("t1_spi_idle",     64'(spi_done), 64'(1));
      repeat (2) @(negedge clk);
      chk("t1_idle_busy", 64'(busy), 64'(0));
      chk("t1_idle_ncs",  64'(nCS), 64'(1));
      chk("t1_no_ld",     64'(ldq.size()), 64'(0));

      // ---- T2/T3 single write ----
      l0 = ldq.size(); g0 = gapq.size(); r0 = rise_cnt; b0 = rxq.size();
      start_wr(16'h1234, 8'hA5);
      chk("t2_busy_after_accept", 64'(busy), 64'(1));
      chk("t2_ncs_low",           64'(nCS), 64'(0));
      for (int i = 0; i < 2000 && done_cnt < 1; i++) @(negedge clk);
      chk("t2_done_count", 64'(done_cnt), 64'(1));
      chk("t2_bytes",      64'(ld5(l0)), 64'(40'h06_02_12_34_A5));
      chk("t2_ld_count",   64'(ldq.size() - l0), 64'(5));
      chk("t2_ncs_rises",  64'(rise_cnt - r0), 64'(2));
      chk("t2_gap_ge8",    64'((gapq.size() > g0 + 1) ? (gapq[g0+1] >= 8) : 0), 64'(1));
      chk("t2_twc_dist",   64'(done_cyc - rise_cyc), 64'(TWC_T));
      chk("t2_busy_clear", 64'(busy), 64'(0));
      chk("t3_bit_count",  64'(rxq.size() - b0), 64'(40));
      chk("t3_stream",     64'(rx40(b0)), 64'(40'b00000110_00000010_00010010_00110100_10100101));

      // ---- T4 request while busy ----
      l0 = ldq.size(); d0 = done_cnt;
      start_wr(16'h1234, 8'hA5);
      for (int i = 0; i < 500 && ldq.size() < l0 + 2; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      start_wr(16'hFFFF, 8'h00);
      for (int i = 0; i < 2000 && done_cnt < d0 + 1; i++) @(negedge clk);
      chk("t4_bytes", 64'(ld5(l0)), 64'(40'h06_02_12_34_A5));
      repeat (30) @(negedge clk);
      chk("t4_one_done", 64'(done_cnt - d0), 64'(1));
      chk("t4_ld_count", 64'(ldq.size() - l0), 64'(5));
      chk("t4_idle",     64'(busy), 64'(0));

      // ---- T5 back-to-back ----
      l0 = ldq.size(); d0 = done_cnt;
      @(negedge clk);
      wr_addr = 16'h0001; wr_data = 8'h5A; wr_req = 1'b1;
      for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
      chk("t5_done_seen",    64'(done), 64'(1));
      chk("t5_busy_at_done", 64'(busy), 64'(0));
      @(negedge clk);
      chk("t5_accept_cycle_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("t5_restart_busy", 64'(busy), 64'(1));
      chk("t5_restart_ncs",  64'(nCS), 64'(0));
      wr_req = 1'b0;
      for (int i = 0; i < 2000 && done_cnt < d0 + 2; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      chk("t5_two_done", 64'(done_cnt - d0), 64'(2));
      chk("t5_bytes_a",  64'(ld5(l0)), 64'(40'h06_02_00_01_5A));
      chk("t5_bytes_b",  64'(ld5(l0 + 5)), 64'(40'h06_02_00_01_5A));

      // ---- T6 mid-frame reset ----
      l0 = ldq.size(); d0 = done_cnt;
      start_wr(16'h1234, 8'hA5);
      for (int i = 0; i < 500 && ldq.size() < l0 + 3; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      chk("t6_in_addr_h", 64'(ldq.size() - l0), 64'(3));
      chk("t6_shifting",  64'(nCS), 64'(0));
      rst_n = 1'b0;
      #1;
      chk("t6_ncs_async", 64'(nCS), 64'(1));
      chk("t6_ld_async",  64'(ld_data), 64'(0));
      chk("t6_busy_init", 64'(busy), 64'(1));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100 && spi_done !== 1'b1; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("t6_idle_busy", 64'(busy), 64'(0));
      chk("t6_idle_ncs",  64'(nCS), 64'(1));
      repeat (300) @(negedge clk);
      chk("t6_no_done",   64'(done_cnt - d0), 64'(0));
      chk("t6_no_ld",     64'(ldq.size() - l0), 64'(3));

      chk("viol_ld_while_ncs_high", 64'(viol_ld), 64'(0));
      chk("viol_ncs_while_shift",   64'(viol_cs), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
